// File: rtl/reservation_station_param.sv
// Parameterised reservation station: CDB wakeup, allocation bypass, single issue port.
// Define RS_AGE_SELECT_EN to issue the oldest ready entry instead of the lowest-index one.
module reservation_station_param #(
  parameter int RS_SIZE = 16,
  parameter int ROB_W   = 4,
  parameter int OP_W    = 6,
  parameter int NUM_CDB = 2
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     rdy_in,
  input  logic                     flush_in,
  input  logic                     alloc_valid_in,
  input  logic [OP_W-1:0]          alloc_op_in,
  input  logic [ROB_W-1:0]         alloc_rob_in,
  input  logic [31:0]              alloc_vj_in,
  input  logic [31:0]              alloc_vk_in,
  input  logic                     alloc_qj_valid_in,
  input  logic                     alloc_qk_valid_in,
  input  logic [ROB_W-1:0]         alloc_qj_in,
  input  logic [ROB_W-1:0]         alloc_qk_in,
  output logic                     full_out,
  output logic [$clog2(RS_SIZE):0] count_out,
  input  logic [NUM_CDB-1:0]       cdb_valid_in,
  input  logic [NUM_CDB*ROB_W-1:0] cdb_rob_in,
  input  logic [NUM_CDB*32-1:0]    cdb_value_in,
  output logic                     iss_valid_out,
  input  logic                     iss_ready_in,
  output logic [OP_W-1:0]          iss_op_out,
  output logic [31:0]              iss_vj_out,
  output logic [31:0]              iss_vk_out,
  output logic [ROB_W-1:0]         iss_rob_out
);
  localparam int IDX_W = $clog2(RS_SIZE);
  localparam int CNT_W = IDX_W + 1;

  logic             busy_reg     [RS_SIZE];
  logic             qj_valid_reg [RS_SIZE];
  logic             qk_valid_reg [RS_SIZE];
  logic [OP_W-1:0]  op_reg       [RS_SIZE];
  logic [ROB_W-1:0] rob_reg      [RS_SIZE];
  logic [ROB_W-1:0] qj_reg       [RS_SIZE];
  logic [ROB_W-1:0] qk_reg       [RS_SIZE];
  logic [31:0]      vj_reg       [RS_SIZE];
  logic [31:0]      vk_reg       [RS_SIZE];
  logic [CNT_W-1:0] count_reg;

  logic [RS_SIZE-1:0] busy_vec, ready_vec, cand_vec;
  logic [IDX_W-1:0]   alloc_idx, iss_idx;
  logic               alloc_fire, iss_fire;

  function automatic logic cdb_hit(input logic [ROB_W-1:0] tag);
    cdb_hit = 1'b0;
    for (int c = 0; c < NUM_CDB; c++)
      if (cdb_valid_in[c] && cdb_rob_in[c*ROB_W +: ROB_W] == tag) cdb_hit = 1'b1;
  endfunction

  // Scan from the top so the lowest matching channel is the last one written.
  function automatic logic [31:0] cdb_val(input logic [ROB_W-1:0] tag);
    cdb_val = '0;
    for (int c = NUM_CDB - 1; c >= 0; c--)
      if (cdb_valid_in[c] && cdb_rob_in[c*ROB_W +: ROB_W] == tag) cdb_val = cdb_value_in[c*32 +: 32];
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < RS_SIZE; gi++) begin : g_entry
      assign busy_vec[gi]  = busy_reg[gi];
      assign ready_vec[gi] = busy_reg[gi] & ~qj_valid_reg[gi] & ~qk_valid_reg[gi];

      always_ff @(posedge clk_in) begin
        if (!rst_in) begin
          busy_reg[gi]     <= 1'b0;
          qj_valid_reg[gi] <= 1'b0;
          qk_valid_reg[gi] <= 1'b0;
        end else if (rdy_in) begin
          if (flush_in) begin
            busy_reg[gi] <= 1'b0;
          end else if (alloc_fire && alloc_idx == IDX_W'(gi)) begin
            busy_reg[gi]     <= 1'b1;
            op_reg[gi]       <= alloc_op_in;
            rob_reg[gi]      <= alloc_rob_in;
            qj_reg[gi]       <= alloc_qj_in;
            qk_reg[gi]       <= alloc_qk_in;
            qj_valid_reg[gi] <= alloc_qj_valid_in & ~cdb_hit(alloc_qj_in);
            qk_valid_reg[gi] <= alloc_qk_valid_in & ~cdb_hit(alloc_qk_in);
            vj_reg[gi] <= (alloc_qj_valid_in && cdb_hit(alloc_qj_in)) ? cdb_val(alloc_qj_in) : alloc_vj_in;
            vk_reg[gi] <= (alloc_qk_valid_in && cdb_hit(alloc_qk_in)) ? cdb_val(alloc_qk_in) : alloc_vk_in;
          end else begin
            if (iss_fire && iss_idx == IDX_W'(gi)) busy_reg[gi] <= 1'b0;
            if (qj_valid_reg[gi] && cdb_hit(qj_reg[gi])) begin
              qj_valid_reg[gi] <= 1'b0;
              vj_reg[gi]       <= cdb_val(qj_reg[gi]);
            end
            if (qk_valid_reg[gi] && cdb_hit(qk_reg[gi])) begin
              qk_valid_reg[gi] <= 1'b0;
              vk_reg[gi]       <= cdb_val(qk_reg[gi]);
            end
          end
        end
      end
    end
  endgenerate

  always_comb begin
    alloc_idx = '0;
    for (int i = RS_SIZE - 1; i >= 0; i--)
      if (!busy_vec[i]) alloc_idx = IDX_W'(i);
  end

`ifdef RS_AGE_SELECT_EN
  // age_reg[j][i] set means entry j was allocated before entry i.
  logic [RS_SIZE-1:0] age_reg [RS_SIZE];

  always_ff @(posedge clk_in) begin
    if (alloc_fire) begin
      for (int j = 0; j < RS_SIZE; j++) begin
        if (j == int'(alloc_idx)) age_reg[j] <= '0;
        else                      age_reg[j][alloc_idx] <= 1'b1;
      end
    end
  end

  always_comb begin
    cand_vec = ready_vec;
    for (int i = 0; i < RS_SIZE; i++)
      for (int j = 0; j < RS_SIZE; j++)
        if (j != i && ready_vec[j] && age_reg[j][i]) cand_vec[i] = 1'b0;
  end
`else
  assign cand_vec = ready_vec;
`endif

  always_comb begin
    iss_idx = '0;
    for (int i = RS_SIZE - 1; i >= 0; i--)
      if (cand_vec[i]) iss_idx = IDX_W'(i);
  end

  assign full_out      = &busy_vec;
  assign count_out     = count_reg;
  assign alloc_fire    = alloc_valid_in & ~full_out & rdy_in & ~flush_in;
  assign iss_valid_out = (|cand_vec) & rdy_in;
  assign iss_fire      = iss_valid_out & iss_ready_in & ~flush_in;
  assign iss_op_out    = iss_valid_out ? op_reg[iss_idx]  : '0;
  assign iss_rob_out   = iss_valid_out ? rob_reg[iss_idx] : '0;
  assign iss_vj_out    = iss_valid_out ? vj_reg[iss_idx]  : '0;
  assign iss_vk_out    = iss_valid_out ? vk_reg[iss_idx]  : '0;

  always_ff @(posedge clk_in) begin
    if (!rst_in)       count_reg <= '0;
    else if (rdy_in) begin
      if (flush_in)    count_reg <= '0;
      else             count_reg <= count_reg + CNT_W'(alloc_fire) - CNT_W'(iss_fire);
    end
  end
endmodule

// File: doc/reservation_station_param.md
RESERVATION_STATION_PARAM -- requirements
Module: reservation_station_param

Interface
REQ-001 SHALL have parameter RS_SIZE, default 16: number of entries, power of two, 2..32.
REQ-002 SHALL have parameter ROB_W, default 4: RoB index width.
REQ-003 SHALL have parameter OP_W, default 6: opcode width.
REQ-004 SHALL have parameter NUM_CDB, default 2: number of CDB broadcast channels, 1..4.
REQ-005 SHALL have port clk_in  input  1  sole clock; all state updates on its rising edge.
REQ-006 SHALL have port rst_in  input  1  reset, synchronous, active-low.
REQ-007 SHALL have port rdy_in  input  1  global enable; low freezes all state.
REQ-008 SHALL have port flush_in  input  1  mispredict flush.
REQ-009 SHALL have port alloc_valid_in  input  1  allocation request.
REQ-010 SHALL have ports alloc_op_in (OP_W), alloc_rob_in (ROB_W), alloc_vj_in/alloc_vk_in (32), alloc_qj_valid_in/alloc_qk_valid_in (1), alloc_qj_in/alloc_qk_in (ROB_W), all inputs: new entry contents; q*_valid high = operand pending on that RoB tag.
REQ-011 SHALL have port full_out  output  1  no free entry.
REQ-012 SHALL have port count_out  output  clog2(RS_SIZE)+1  number of busy entries.
REQ-013 SHALL have ports cdb_valid_in (NUM_CDB), cdb_rob_in (NUM_CDB*ROB_W), cdb_value_in (NUM_CDB*32), all inputs: packed CDB channels, channel i in slice i.
REQ-014 SHALL have ports iss_valid_out (1, output), iss_ready_in (1, input): issue handshake to execution unit.
REQ-015 SHALL have outputs iss_op_out (OP_W), iss_vj_out (32), iss_vk_out (32), iss_rob_out (ROB_W): issued entry contents.

Function
REQ-016 Allocation SHALL occur when alloc_valid_in & !full_out & rdy_in & !flush_in, into the lowest-index free entry.
REQ-017 full_out and count_out SHALL derive from registered state only; an entry freed by issue in the same cycle SHALL NOT be reusable until the next cycle.
REQ-018 Each cycle with rdy_in high, every busy entry with qj/qk pending matching any valid CDB channel tag SHALL capture that channel's value and clear the pending bit; multiple matches SHALL take the lowest channel.
REQ-019 Allocation bypass: an allocated operand whose tag matches a valid CDB channel in the same cycle SHALL be stored as ready with the CDB value.
REQ-020 An entry SHALL be ready when busy and both operands non-pending in registered state (wakeup-to-issue latency 1 cycle).
REQ-021 iss_valid_out SHALL be combinational: high iff any ready entry exists and rdy_in high; iss_* fields from the selected entry, zero when none.
REQ-022 The selected entry SHALL be freed on a clock edge where iss_valid_out & iss_ready_in; selection MAY change while unaccepted, and the consumer samples only at handshake.
REQ-023 Allocation, wakeup and issue SHALL proceed concurrently in one cycle; count_out SHALL update by +alloc -issue.
REQ-024 flush_in high SHALL clear all busy bits at the next edge, override same-cycle allocation and issue, and zero count_out.
REQ-025 rdy_in low SHALL hold all state; CDB broadcasts in that cycle are ignored.

Reset
REQ-026 rst_in low at a rising edge SHALL clear all busy and pending bits and zero count_out, regardless of rdy_in and flush_in; afterwards full_out=0, iss_valid_out=0, iss_* fields=0.
REQ-027 Entry payload registers need not be reset.

Configuration
REQ-028 With RS_AGE_SELECT_EN defined, an RS_SIZE x RS_SIZE age matrix SHALL be kept and issue SHALL select the oldest ready entry by allocation order.
REQ-029 Without RS_AGE_SELECT_EN, issue SHALL select the lowest-index ready entry, with no age storage.

Verification
REQ-030 Reset then alloc op=5, rob=3, vj=10, vk=20, both ready, iss_ready_in=1 -> next cycle iss_valid_out=1, iss_rob_out=3, vj=10, vk=20; following cycle count_out=0.
REQ-031 Alloc rob=1 with qj pending tag 7; CDB ch1 tag=7, value=0xDEAD two cycles later -> iss_vj_out=0xDEAD one cycle after broadcast.
REQ-032 Alloc with qk tag 2 while CDB ch0 broadcasts tag 2, value 0x55 in the same cycle -> entry ready next cycle, iss_vk_out=0x55.
REQ-033 Fill RS_SIZE entries with iss_ready_in=0 -> full_out=1, count_out=RS_SIZE; further alloc_valid_in ignored; assert flush_in -> next cycle count_out=0, full_out=0.
REQ-034 RS_AGE_SELECT_EN: alloc A into entry 0 pending, B into entry 1 ready, free entry 0, C into entry 0 ready -> B issues before C; without macro C issues first.
